dl11_buffered: RTL and testbench

Parametrised successor to the single-line DL11 teletype interface. Presents the standard four-register DL11 (RCSR/RBUF/XCSR/XBUF) Unibus slave at a configurable base address and vector, with receive and transmit FIFOs between the Unibus and the ARM register port, maintenance loopback, and overrun reporting. Sits on the Unibus beside the other slaves; the ARM side feeds keyboard characters and drains printer characters.

---
 rtl/dl11_pkg.sv | 21 ++
 rtl/dl11_fifo.sv | 54 +++++
 rtl/dl11_buffered.sv | 203 ++++++++++++++++++++
 tb/tb_dl11_buffered.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dl11_pkg.sv
// dl11_pkg: shared constants for the buffered DL11 serial line.
// Register offsets, CSR bit positions, ident word and slave FSM states.
package dl11_pkg;

  localparam logic [1:0] R_RCSR = 2'd0;
  localparam logic [1:0] R_RBUF = 2'd1;
  localparam logic [1:0] R_XCSR = 2'd2;
  localparam logic [1:0] R_XBUF = 2'd3;

  localparam int CSR_DONE  = 7;
  localparam int CSR_IE    = 6;
  localparam int CSR_MAINT = 2;

  localparam logic [31:0] IDENT = 32'h444C1002;

  typedef enum logic {
    S_IDLE,
    S_ACK
  } state_t;

endpackage

// File: rtl/dl11_fifo.sv
// dl11_fifo: 8-bit FIFO with occupancy count.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module dl11_fifo #(
  parameter int LOG2 = 4
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          push,
  input  logic          pop,
  input  logic [7:0]    din,
  output logic [7:0]    head,
  output logic [LOG2:0] count,
  output logic          full,
  output logic          empty,
  output logic          drop
);

  localparam int DEPTH = 1 << LOG2;
  localparam logic [LOG2:0] FULLC = {1'b1, {LOG2{1'b0}}};

  logic [7:0]      mem [DEPTH];
  logic [LOG2-1:0] wr_ptr;
  logic [LOG2-1:0] rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULLC);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign drop    = push & ~do_push;
  assign head    = mem[rd_ptr];

  // storage write; contents need no reset
  always_ff @(posedge clk) begin
    if (do_push && !clr)
      mem[wr_ptr] <= din;
  end

  // pointers and count, wrapping modulo depth
  always_ff @(posedge clk) begin
    if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{LOG2{1'b0}}, do_push}
                     - {{LOG2{1'b0}}, do_pop};
    end
  end

endmodule

// File: rtl/dl11_buffered.sv
// dl11_buffered: DL11 Unibus slave with RX/TX FIFOs and ARM register port.
// Loopback via MAINT, overrun flag on dropped receive characters.
module dl11_buffered
  import dl11_pkg::*;
#(
  parameter logic [17:0] ADDR   = 18'o777560,
  parameter logic [8:0]  INTVEC = 9'o060,
  parameter int          RXLOG2 = 4,
  parameter int          TXLOG2 = 2
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        armwrite,
  input  logic [1:0]  armraddr,
  input  logic [1:0]  armwaddr,
  input  logic [31:0] armwdata,
  output logic [31:0] armrdata,
  input  logic [17:0] bus_a_in_l,
  input  logic [1:0]  bus_c_in_l,
  input  logic [15:0] bus_d_in_l,
  input  logic        bus_msyn_in_l,
  input  logic        bus_init_in_l,
  output logic [15:0] bus_d_out_l,
  output logic        bus_ssyn_out_l,
  output logic        rintreq,
  output logic        xintreq,
  input  logic        rintgnt,
  input  logic        xintgnt,
  output logic [8:0]  intvec
);

  logic [17:0] ba;
  logic [1:0]  bc;
  logic [15:0] bd;
  logic        msyn, clr;
  logic        enable, rie, xie, maint, ovr;
  logic [7:0]  xbuf_q;
  logic [15:0] rdat_q, bus_rmux;
  logic        rd_q;
  state_t      state, next;
  logic        sel, strobe, wr, lo_we;
  logic [1:0]  ra;
  logic        bus_push, rx_pop, arm_rx_push, arm_tx_pop;
  logic        maint_push, tx_push, rx_push, collide;
  logic [7:0]  rx_din, rx_head, tx_head;
  logic [RXLOG2:0] rx_count;
  logic [TXLOG2:0] tx_count;
  logic        rx_full, rx_empty, rx_drop;
  logic        tx_full, tx_empty, tx_drop;
  logic        rcond, rcond_q, xcond, xcond_q;
  logic        unused;

  assign ba   = ~bus_a_in_l;
  assign bc   = ~bus_c_in_l;
  assign bd   = ~bus_d_in_l;
  assign msyn = ~bus_msyn_in_l;
  assign clr  = RESET | ~bus_init_in_l;

  assign sel    = enable & msyn & (ba[17:3] == ADDR[17:3]);
  assign strobe = (state == S_IDLE) & sel;
  assign wr     = bc[1];
  assign ra     = ba[2:1];
  assign lo_we  = wr & ~(bc[0] & ba[0]);

  assign bus_push    = strobe & lo_we & (ra == R_XBUF);
  assign rx_pop      = strobe & ~wr & (ra == R_RBUF);
  assign arm_rx_push = armwrite & (armwaddr == 2'd1) & armwdata[31];
  assign arm_tx_pop  = armwrite & (armwaddr == 2'd2) & armwdata[31];
  assign maint_push  = bus_push & maint;
  assign tx_push     = bus_push & ~maint;
  assign rx_push     = arm_rx_push | maint_push;
  assign rx_din      = maint_push ? bd[7:0] : armwdata[7:0];
  assign collide     = arm_rx_push & maint_push;

  assign unused = ^{bd[15:8], armwdata[30:8], tx_drop};

  dl11_fifo #(.LOG2(RXLOG2)) u_rx (
    .clk(CLOCK), .clr(clr), .push(rx_push), .pop(rx_pop),
    .din(rx_din), .head(rx_head), .count(rx_count),
    .full(rx_full), .empty(rx_empty), .drop(rx_drop)
  );

  dl11_fifo #(.LOG2(TXLOG2)) u_tx (
    .clk(CLOCK), .clr(clr), .push(tx_push), .pop(arm_tx_pop),
    .din(bd[7:0]), .head(tx_head), .count(tx_count),
    .full(tx_full), .empty(tx_empty), .drop(tx_drop)
  );

  // bus register read mux, captured at ACK entry
  always_comb begin
    bus_rmux = '0;
    unique case (ra)
      R_RCSR: begin
        bus_rmux[CSR_DONE] = ~rx_empty;
        bus_rmux[CSR_IE]   = rie;
      end
      R_RBUF: bus_rmux = {ovr, ovr, 6'b0, rx_head};
      R_XCSR: begin
        bus_rmux[CSR_DONE]  = ~tx_full;
        bus_rmux[CSR_IE]    = xie;
        bus_rmux[CSR_MAINT] = maint;
      end
      R_XBUF: bus_rmux = {8'b0, xbuf_q};
    endcase
  end

  // slave FSM state register
  always_ff @(posedge CLOCK) begin
    if (RESET) state <= S_IDLE;
    else       state <= next;
  end

  // slave FSM next state; INIT does not abort a cycle
  always_comb begin
    next = state;
    unique case (state)
      S_IDLE: if (sel)   next = S_ACK;
      S_ACK:  if (!msyn) next = S_IDLE;
    endcase
  end

  // slave FSM outputs
  always_comb begin
    bus_ssyn_out_l = 1'b1;
    bus_d_out_l    = 16'o177777;
    if (state == S_ACK) begin
      bus_ssyn_out_l = 1'b0;
      if (rd_q) bus_d_out_l = ~rdat_q;
    end
  end

  // hold read data for the whole ACK phase
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      rdat_q <= '0;
      rd_q   <= 1'b0;
    end else if (strobe) begin
      rdat_q <= bus_rmux;
      rd_q   <= ~wr;
    end
  end

  // CSR bits, overrun flag and last XBUF byte
  always_ff @(posedge CLOCK) begin
    if (RESET) xbuf_q <= '0;
    else if (bus_push) xbuf_q <= bd[7:0];
    if (clr) begin
      rie   <= 1'b0;
      xie   <= 1'b0;
      maint <= 1'b0;
      ovr   <= 1'b0;
    end else begin
      if (strobe && lo_we && ra == R_RCSR)
        rie <= bd[CSR_IE];
      if (strobe && lo_we && ra == R_XCSR) begin
        xie   <= bd[CSR_IE];
        maint <= bd[CSR_MAINT];
      end
      if (rx_drop || collide) ovr <= 1'b1;
      else if (rx_pop)        ovr <= 1'b0;
    end
  end

  // Unibus decode enable, only touched by RESET and ARM reg 3
  always_ff @(posedge CLOCK) begin
    if (RESET) enable <= 1'b1;
    else if (armwrite && armwaddr == 2'd3)
      enable <= armwdata[31];
  end

  assign rcond = rie & ~rx_empty;
  assign xcond = xie & ~tx_full;

  // interrupt requests: set on rising condition, drop on grant or fall
  always_ff @(posedge CLOCK) begin
    if (clr) begin
      rcond_q <= 1'b0;
      xcond_q <= 1'b0;
      rintreq <= 1'b0;
      xintreq <= 1'b0;
    end else begin
      rcond_q <= rcond;
      xcond_q <= xcond;
      rintreq <= (rcond & ~rcond_q) | (rintreq & rcond & ~rintgnt);
      xintreq <= (xcond & ~xcond_q) | (xintreq & xcond & ~xintgnt);
    end
  end

  assign intvec = (!rintreq && xintreq) ? INTVEC + 9'd4 : INTVEC;

  // ARM register read port
  always_comb begin
    armrdata = '0;
    unique case (armraddr)
      2'd0: armrdata = IDENT;
      2'd1: armrdata = {rx_full, rx_empty, 22'b0, 8'(rx_count)};
      2'd2: armrdata = {~tx_empty, tx_full, 6'b0, 8'(tx_count),
                        8'b0, tx_head};
      2'd3: armrdata = {enable, 4'b0, INTVEC, ADDR};
    endcase
  end

endmodule

// File: tb/tb_dl11_buffered.sv
// tb_dl11_buffered: directed scoreboard bench for dl11_buffered.
// Expected values are queued by stimulus and consumed by a negedge monitor.
module tb_dl11_buffered;

  logic        CLOCK = 1'b0;
  logic        RESET = 1'b1;
  logic        armwrite = 1'b0;
  logic [1:0]  armraddr = 2'd0;
  logic [1:0]  armwaddr = 2'd0;
  logic [31:0] armwdata = '0;
  logic [31:0] armrdata;
  logic [17:0] bus_a_in_l = '1;
  logic [1:0]  bus_c_in_l = '1;
  logic [15:0] bus_d_in_l = '1;
  logic        bus_msyn_in_l = 1'b1;
  logic        bus_init_in_l = 1'b1;
  logic [15:0] bus_d_out_l;
  logic        bus_ssyn_out_l;
  logic        rintreq, xintreq;
  logic        rintgnt = 1'b0;
  logic        xintgnt = 1'b0;
  logic [8:0]  intvec;

  localparam logic [17:0] A_RCSR = 18'o777560;
  localparam logic [17:0] A_RBUF = 18'o777562;
  localparam logic [17:0] A_XCSR = 18'o777564;
  localparam logic [17:0] A_XBUF = 18'o777566;
  localparam logic [31:0] REG3   = 32'h80C3FF70;

  localparam int S_BUS = 0, S_ARM = 1, S_RIRQ = 2, S_XIRQ = 3;
  localparam int S_VEC = 4, S_SSYN = 5, S_DOUT = 6;

  typedef struct {
    string       name;
    int          src;
    logic [31:0] exp;
    logic [31:0] mask;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;
  logic probe_go = 1'b0;
  logic rd_act = 1'b0;
  logic ssyn_prev = 1'b1;

  dl11_buffered dut (
    .CLOCK(CLOCK), .RESET(RESET),
    .armwrite(armwrite), .armraddr(armraddr), .armwaddr(armwaddr),
    .armwdata(armwdata), .armrdata(armrdata),
    .bus_a_in_l(bus_a_in_l), .bus_c_in_l(bus_c_in_l),
    .bus_d_in_l(bus_d_in_l), .bus_msyn_in_l(bus_msyn_in_l),
    .bus_init_in_l(bus_init_in_l), .bus_d_out_l(bus_d_out_l),
    .bus_ssyn_out_l(bus_ssyn_out_l),
    .rintreq(rintreq), .xintreq(xintreq),
    .rintgnt(rintgnt), .xintgnt(xintgnt), .intvec(intvec)
  );

  always #5 CLOCK = ~CLOCK;

  function automatic logic [31:0] actual(int src);
    case (src)
      S_BUS:  return {16'b0, ~bus_d_out_l};
      S_ARM:  return armrdata;
      S_RIRQ: return {31'b0, rintreq};
      S_XIRQ: return {31'b0, xintreq};
      S_VEC:  return {23'b0, intvec};
      S_SSYN: return {31'b0, bus_ssyn_out_l};
      default: return {16'b0, bus_d_out_l};
    endcase
  endfunction

  task automatic compare();
    exp_t e;
    logic [31:0] a;
    e = sb.pop_front();
    a = actual(e.src);
    vectors++;
    if ((a & e.mask) !== (e.exp & e.mask)) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (mask %h)",
               e.name, a & e.mask, e.exp & e.mask, e.mask);
    end
  endtask

  // monitor: bus read data on SSYN assertion, other probes on request
  always @(negedge CLOCK) begin
    if (rd_act && ssyn_prev && !bus_ssyn_out_l && sb.size() > 0)
      compare();
    else if (probe_go && sb.size() > 0)
      compare();
    ssyn_prev = bus_ssyn_out_l;
  end

  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic timeout(string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: timeout got no SSYN expected handshake", name);
  endtask

  task automatic expect_v(int src, logic [1:0] ra, logic [31:0] exp,
                          string name, logic [31:0] mask = 32'hFFFFFFFF);
    armraddr = ra;
    sb.push_back('{name: name, src: src, exp: exp, mask: mask});
    probe_go = 1'b1;
    @(negedge CLOCK);
    #1 probe_go = 1'b0;
    tick();
  endtask

  task automatic arm_wr(logic [1:0] r, logic [31:0] d);
    armwaddr = r;
    armwdata = d;
    armwrite = 1'b1;
    tick();
    armwrite = 1'b0;
  endtask

  task automatic bus_end();
    bus_msyn_in_l = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (bus_ssyn_out_l) break;
      tick();
    end
    tick();
    bus_a_in_l = '1;
    bus_c_in_l = '1;
    bus_d_in_l = '1;
  endtask

  task automatic bus_rd(logic [17:0] a, logic [15:0] exp, string name,
                        bit push = 1'b0, logic [7:0] pd = 8'h00);
    bit ok;
    sb.push_back('{name: name, src: S_BUS, exp: {16'b0, exp},
                   mask: 32'h0000FFFF});
    rd_act = 1'b1;
    bus_a_in_l = ~a;
    bus_c_in_l = ~2'b00;
    bus_msyn_in_l = 1'b0;
    if (push) begin
      armwaddr = 2'd1;
      armwdata = {1'b1, 23'b0, pd};
      armwrite = 1'b1;
    end
    tick();
    armwrite = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (!bus_ssyn_out_l) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (ok) begin
      @(negedge CLOCK);
      #1;
    end else begin
      if (sb.size() > 0) void'(sb.pop_back());
      timeout(name);
    end
    rd_act = 1'b0;
    bus_end();
  endtask

  task automatic bus_wr(logic [17:0] a, logic [15:0] d, bit bytew,
                        string name);
    bit ok;
    bus_a_in_l = ~a;
    bus_c_in_l = bytew ? ~2'b11 : ~2'b10;
    bus_d_in_l = ~d;
    bus_msyn_in_l = 1'b0;
    tick();
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (!bus_ssyn_out_l) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) timeout(name);
    tick();
    bus_end();
  endtask

  initial begin
    repeat (3) tick();
    RESET = 1'b0;
    tick();

    // reset state
    expect_v(S_SSYN, 2'd0, 32'd1, "rst_ssyn");
    expect_v(S_DOUT, 2'd0, 32'h0000FFFF, "rst_dout");
    expect_v(S_RIRQ, 2'd0, 32'd0, "rst_rintreq");
    expect_v(S_XIRQ, 2'd0, 32'd0, "rst_xintreq");
    expect_v(S_VEC, 2'd0, 32'o060, "rst_intvec");
    expect_v(S_ARM, 2'd0, 32'h444C1002, "ident");
    expect_v(S_ARM, 2'd3, REG3, "reg3_rst");
    bus_rd(A_XCSR, 16'o000200, "xcsr_rst");
    bus_rd(A_RCSR, 16'o000000, "rcsr_rst");

    // ARM pushes A, B; bus drains
    arm_wr(2'd1, 32'h80000041);
    arm_wr(2'd1, 32'h80000042);
    expect_v(S_ARM, 2'd1, 32'h00000002, "rx_cnt2");
    bus_rd(A_RCSR, 16'o000200, "rcsr_done");
    bus_rd(A_RBUF, 16'o000101, "rbuf_A");
    bus_rd(A_RBUF, 16'o000102, "rbuf_B");
    bus_rd(A_RCSR, 16'o000000, "rcsr_empty");
    expect_v(S_ARM, 2'd1, 32'h40000000, "rx_empty");

    // RX overrun: 17 pushes into 16 entries
    for (int i = 0; i < 17; i++)
      arm_wr(2'd1, 32'h80000041 + i);
    expect_v(S_ARM, 2'd1, 32'h80000010, "rx_full");
    bus_rd(A_RBUF, 16'o140101, "rbuf_ovr");
    bus_rd(A_RBUF, 16'o000102, "rbuf_ovr_clr");

    // TX overflow with depth 4
    for (int i = 0; i < 5; i++)
      bus_wr(A_XBUF, 16'h0031 + 16'(i), 1'b0, "xbuf_wr");
    bus_rd(A_XCSR, 16'o000000, "xcsr_full");
    expect_v(S_ARM, 2'd2, 32'hC0040031, "tx_full");
    arm_wr(2'd2, 32'h80000000);
    bus_rd(A_XCSR, 16'o000200, "xcsr_ready");
    expect_v(S_ARM, 2'd2, 32'h80030032, "tx_pop");
    bus_rd(A_XBUF, 16'o000065, "xbuf_last");

    // enable interrupts, then INIT
    bus_wr(A_RCSR, 16'o000100, 1'b0, "rcsr_ie");
    bus_wr(A_XCSR, 16'o000104, 1'b0, "xcsr_ie");
    expect_v(S_RIRQ, 2'd0, 32'd1, "rirq_pre_init");
    expect_v(S_XIRQ, 2'd0, 32'd1, "xirq_pre_init");
    expect_v(S_VEC, 2'd0, 32'o060, "vec_rx_wins");
    bus_init_in_l = 1'b0;
    tick();
    bus_init_in_l = 1'b1;
    expect_v(S_ARM, 2'd1, 32'h40000000, "init_rx");
    expect_v(S_ARM, 2'd2, 32'h00000000, "init_tx", 32'hFFFF0000);
    expect_v(S_ARM, 2'd3, REG3, "init_enable");
    expect_v(S_RIRQ, 2'd0, 32'd0, "init_rirq");
    expect_v(S_XIRQ, 2'd0, 32'd0, "init_xirq");
    bus_rd(A_RCSR, 16'o000000, "init_rcsr");
    bus_rd(A_XCSR, 16'o000200, "init_xcsr");

    // byte writes: odd byte leaves low-byte bits alone
    bus_wr(A_XCSR | 18'd1, 16'h4444, 1'b1, "xcsr_odd");
    bus_rd(A_XCSR, 16'o000200, "xcsr_odd_rd");
    bus_wr(A_XCSR, 16'o000104, 1'b1, "xcsr_even");
    bus_rd(A_XCSR, 16'o000304, "xcsr_even_rd");

    // maintenance loopback
    bus_wr(A_XBUF, 16'o000132, 1'b0, "maint_wr");
    bus_rd(A_RCSR, 16'o000200, "maint_rcsr");
    expect_v(S_ARM, 2'd2, 32'h00000000, "maint_tx", 32'hFFFF0000);
    bus_rd(A_RBUF, 16'o000132, "maint_rbuf");
    bus_wr(A_XCSR, 16'o000000, 1'b0, "xcsr_clr");

    // receive interrupt and grant
    bus_wr(A_RCSR, 16'o000100, 1'b0, "rie_set");
    arm_wr(2'd1, 32'h80000051);
    expect_v(S_RIRQ, 2'd0, 32'd0, "rirq_lat0");
    expect_v(S_RIRQ, 2'd0, 32'd1, "rirq_lat1");
    expect_v(S_VEC, 2'd0, 32'o060, "rvec");
    rintgnt = 1'b1;
    tick();
    rintgnt = 1'b0;
    expect_v(S_RIRQ, 2'd0, 32'd0, "rirq_gnt");
    bus_rd(A_RCSR, 16'o000300, "rcsr_done_ie");
    bus_wr(A_XCSR, 16'o000100, 1'b0, "xie_set");
    expect_v(S_XIRQ, 2'd0, 32'd1, "xirq");
    expect_v(S_VEC, 2'd0, 32'o064, "xvec");

    // simultaneous ARM push and bus pop on RX
    bus_rd(A_RBUF, 16'o000121, "rbuf_Q_push", 1'b1, 8'h52);
    expect_v(S_ARM, 2'd1, 32'h00000001, "rx_cnt_same");
    bus_rd(A_RBUF, 16'o000122, "rbuf_R");
    expect_v(S_ARM, 2'd1, 32'h40000000, "rx_empty2");

    // decode disabled
    arm_wr(2'd3, 32'h00000000);
    expect_v(S_ARM, 2'd3, REG3 & 32'h7FFFFFFF, "reg3_dis");
    bus_a_in_l = ~A_RCSR;
    bus_c_in_l = ~2'b00;
    bus_msyn_in_l = 1'b0;
    tick();
    tick();
    expect_v(S_SSYN, 2'd0, 32'd1, "dis_ssyn");
    expect_v(S_DOUT, 2'd0, 32'h0000FFFF, "dis_dout");
    bus_end();
    arm_wr(2'd3, 32'h80000000);
    bus_rd(A_RCSR, 16'o000100, "reen_rcsr");

    repeat (5) tick();
    if (sb.size() != 0) begin
      $display("FAIL leftover: got %0d pending expected 0", sb.size());
      miscompares += sb.size();
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected end of test");
    $fatal(1, "watchdog");
  end

endmodule
